matmul_sched: RTL and testbench
===============================

Name: matmul_sched

Overview:
- Round-robin scheduler sharing one matmul engine among NREQ requesters.
- Arbitrates level requests and issues a single-cycle start to the engine.
- Tracks completion on the rising edge of the engine's done, then returns a one-cycle ack to the granted requester.
- Drives grant_id, which the top level uses to steer the x/y/z memory-port muxes to the winner's buffers.

Parameters:
- NREQ, 4, number of requesters (2..16).
- CNT_WIDTH, 16, width of the completed-job counter.
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held until its ack.
- ack  out  NREQ  one-hot, one-cycle pulse when the granted job completes.
- grant_id  out  $clog2(NREQ)  index of the current owner; valid while busy=1.
- busy  out  1  engine owned (states START, WAIT, ACK).
- mm_start  out  1  single-cycle start pulse to the engine.
- mm_done  in  1  engine done level; stays high until the next start.
- jobs_done  out  CNT_WIDTH  count of completed jobs; wraps.
- timeout  out  1  watchdog expiry pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset values: state=IDLE, ack=0, grant_id=0, busy=0, mm_start=0, jobs_done=0, timeout=0, rr pointer=0, mm_done_q=0.
- States: IDLE, START, WAIT, ACK (2-bit enum).
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr pointer upward with wrap; register grant_id; go to START.
  - Otherwise stay in IDLE.
- START:
  - mm_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Completion event = mm_done & ~mm_done_q, where mm_done_q is mm_done registered every cycle.
  - A stale high mm_done left over from the previous job is never treated as completion.
  - On the completion event go to ACK; otherwise stay in WAIT.
- ACK:
  - ack[grant_id]=1 for one cycle.
  - jobs_done increments by 1 and wraps at 2^CNT_WIDTH.
  - rr pointer = grant_id+1, wrapping to 0 when grant_id=NREQ-1.
  - Go to IDLE.
- Latency:
  - req sampled in IDLE at cycle T → mm_start at T+1.
  - Completion event at cycle D → ack at D+1.
  - Minimum gap between ack and the next mm_start is 2 cycles (IDLE, then START).
- Request rules:
  - Dropping req after grant does not abort the job; ack still pulses.
  - A requester that keeps req high after its ack is served again only after the other pending requesters (fairness).
- Simultaneous requests: all bits of req high → grants go 0,1,2,3,0,… in order.
- Outputs are registered except mm_start and ack, which are decoded from state. Decoded outputs must be glitch-free at the clock edge; no combinational path from req.
- Reset mid-job returns to IDLE immediately and emits no ack. The engine is reset by the same reset.
- grant_id is held stable from START through ACK inclusive.

Optional Feature:
- Macro: MATMUL_SCHED_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no completion event, timeout=1 for one cycle and the FSM proceeds to ACK.
  - In that case ack still pulses, so the requester is released, but jobs_done does not increment.
- Without the macro: no counter is built, timeout is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Package matmul_pkg holds:
  - sched_state_t enum {IDLE, START, WAIT, ACK};
  - localparam helper for the grant-id width;
  - default TIMEOUT constant.
- Sub-module rr_arbiter (combinational):
  - inputs: req, pointer;
  - outputs: found and grant index;
  - parameterised by NREQ;
  - instantiated once in matmul_sched.

Test Plan:
- Single request: req=4'b0100 held → mm_start one cycle after sampling, grant_id=2; model mm_done rising 20 cycles later → ack=4'b0100 one cycle after, jobs_done=1.
- Stale done: mm_done held high from the prior job when mm_start fires, drops 1 cycle later, rises again 10 cycles later → exactly one ack, issued after the second rise.
- Fairness: req=4'b1111 held for 8 jobs → grant_id sequence 0,1,2,3,0,1,2,3; jobs_done=8.
- Mid-job reset: reset asserted during WAIT → next cycle busy=0, ack=0, jobs_done=0; req=4'b0001 afterwards → normal grant to 0.
- Drop request: req[1] deasserted during WAIT → ack[1] still pulses on completion; next grant goes to the next pending requester.
- MATMUL_SCHED_TIMEOUT_EN with TIMEOUT=16 and mm_done never rising → timeout pulse 16 cycles into WAIT, ack pulses the next cycle, jobs_done unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared types and constants for the matmul engine scheduler.
//   sched_state_t   : scheduler FSM states (IDLE, START, WAIT, ACK)
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
//   id_width()      : width of a requester index for n requesters (min 1)
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 4096;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set request bit found
// when searching upward from pointer, wrapping past NREQ-1 back to 0.
// Ports:
//   req     in  NREQ     request vector
//   pointer in  IDW      index at which the search starts (highest priority)
//   found   out 1        at least one request bit is set
//   grant   out IDW      index of the selected requester (0 when !found)
// -----------------------------------------------------------------------------
module rr_arbiter
    import matmul_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]           req,
    input  logic [id_width(NREQ)-1:0] pointer,
    output logic                      found,
    output logic [id_width(NREQ)-1:0] grant
);

    localparam int IDW = id_width(NREQ);

    int             idx;
    logic [IDW-1:0] idx_sel;

    always_comb begin
        found   = 1'b0;
        grant   = '0;
        idx     = 0;
        idx_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            // pointer is always < NREQ, so one subtraction is enough to wrap
            idx = int'(pointer) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_sel = IDW'(idx);
            if (!found && req[idx_sel]) begin
                found = 1'b1;
                grant = idx_sel;
            end
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// -----------------------------------------------------------------------------
// matmul_sched
// Round-robin scheduler sharing one matmul engine among NREQ requesters.
// A winning request gets a single-cycle mm_start; the job completes on the
// rising edge of mm_done, after which the owner receives a one-cycle ack.
// grant_id steers the top-level x/y/z memory muxes and is stable from START
// through ACK.
//
// Ports:
//   clock      in   1             system clock
//   reset      in   1             synchronous, active-high reset
//   req        in   NREQ          level requests, held until ack
//   ack        out  NREQ          one-hot completion pulse to the owner
//   grant_id   out  clog2(NREQ)   current owner, valid while busy
//   busy       out  1             engine owned (START/WAIT/ACK)
//   mm_start   out  1             single-cycle engine start
//   mm_done    in   1             engine done level, high until next start
//   jobs_done  out  CNT_WIDTH     completed-job counter (wraps)
//   timeout    out  1             watchdog expiry pulse
//
// Optional build macro: MATMUL_SCHED_TIMEOUT_EN
//   Defined   : a WAIT-state watchdog forces ACK after TIMEOUT cycles with no
//               completion; timeout pulses, jobs_done is not incremented.
//   Undefined : no watchdog, timeout is constant 0, WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     mm_start,
    input  logic                     mm_done,
    output logic [CNT_WIDTH-1:0]     jobs_done,
    output logic                     timeout
);

    localparam int IDW = id_width(NREQ);

    sched_state_t         state_q, state_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [CNT_WIDTH-1:0] jobs_q, jobs_d;
    logic                 busy_q, busy_d;
    logic                 mm_done_q;
    logic                 done_evt;
    logic                 arb_found;
    logic [IDW-1:0]       arb_grant;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (req),
        .pointer(rr_q),
        .found  (arb_found),
        .grant  (arb_grant)
    );

    // Only a rising edge counts: done stays high from the previous job until
    // the engine sees the next start, so the level alone is stale.
    assign done_evt = mm_done & ~mm_done_q;

`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;
    logic           wd_expire;

    // The registered pulse lands on the last WAIT cycle (count TIMEOUT-1),
    // so it is raised one count earlier; ACK follows on the next cycle.
    assign wd_expire = (state_q == WAIT) && !done_evt && (wd_cnt_q == WDW'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        if (state_q == START) begin
            wd_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wd_cnt_d  = wd_cnt_q + WDW'(1);
            timeout_d = !done_evt && (wd_cnt_q == WDW'(TIMEOUT - 2));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic wd_expire;

    assign wd_expire = 1'b0;
    // TIMEOUT is a positive cycle count, so this is a constant 0; referencing
    // it keeps the parameter list identical in both builds.
    assign timeout   = (TIMEOUT < 1);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        jobs_d  = jobs_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_grant;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // jobs_done advances on entry to ACK so it is already current
                // while ack is visible; a watchdog exit does not count.
                if (done_evt) begin
                    jobs_d  = jobs_q + CNT_WIDTH'(1);
                    state_d = ACK;
                end else if (wd_expire) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                rr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            jobs_q    <= '0;
            busy_q    <= 1'b0;
            mm_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            jobs_q    <= jobs_d;
            busy_q    <= busy_d;
            mm_done_q <= mm_done;
        end
    end

    // mm_start and ack decode straight from the state register, so they are
    // glitch-free at the edge and have no path from req.
    always_comb begin
        ack = '0;
        if (state_q == ACK) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign mm_start  = (state_q == START);
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign jobs_done = jobs_q;

endmodule

// File: tb/tb_matmul_sched.sv
// -----------------------------------------------------------------------------
// tb_matmul_sched
// Directed bench for matmul_sched (NREQ=4). Inputs change and outputs are
// sampled on the falling clock edge. Expected grant owners are queued when
// requests are driven and popped when the DUT issues mm_start; the popped
// owner is then compared against grant_id and the later ack.
// -----------------------------------------------------------------------------
module tb_matmul_sched;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            mm_start;
    logic            mm_done;
    logic [CW-1:0]   jobs_done;
    logic            timeout;

    int checks   = 0;
    int failures = 0;
    int exp_jobs = 0;
    int sb[$];

    matmul_sched #(
        .NREQ     (NREQ),
        .CNT_WIDTH(CW),
        .TIMEOUT  (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .jobs_done(jobs_done),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for mm_start; n = falling edges waited.
    task automatic wait_start(output int n);
        n = 0;
        while (mm_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("start_seen", {31'd0, mm_start}, 32'd1);
    endtask

    // Serve one job as the engine: exp_gap is the expected number of cycles
    // from the call to mm_start; stale keeps the previous done high for two
    // cycles past start; drop clears request bits during WAIT.
    task automatic do_job(input int delay, input bit stale, input logic [NREQ-1:0] drop,
                          input int exp_gap);
        int n;
        int gid;
        wait_start(n);
        chk("start_latency", n, exp_gap);
        gid = (sb.size() > 0) ? sb.pop_front() : -1;
        chk("grant_id", {30'd0, grant_id}, gid);
        chk("busy_start", {31'd0, busy}, 32'd1);
        if (!stale) mm_done = 1'b0;
        step();
        chk("start_one_cycle", {31'd0, mm_start}, 32'd0);
        req = req & ~drop;
        if (stale) begin
            step();
            chk("stale_no_ack", {28'd0, ack}, 32'd0);
            mm_done = 1'b0;
        end
        repeat (delay) begin
            step();
            chk("ack_quiet", {28'd0, ack}, 32'd0);
        end
        mm_done = 1'b1;
        step();
        chk("ack", {28'd0, ack}, 32'd1 << gid);
        exp_jobs++;
        chk("jobs_done", {16'd0, jobs_done}, exp_jobs);
        chk("grant_hold", {30'd0, grant_id}, gid);
        chk("busy_ack", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        req     = '0;
        mm_done = 1'b0;
        repeat (3) step();
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, mm_start}, 32'd0);
        chk("rst_jobs", {16'd0, jobs_done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        step();
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Fairness: all requesters held for 8 jobs
        req = 4'b1111;
        for (int k = 0; k < 8; k++) sb.push_back(k % 4);
        for (int k = 0; k < 8; k++) do_job(3 + k, 1'b0, '0, (k == 0) ? 1 : 2);
        req = '0;
        chk("fair_jobs", {16'd0, jobs_done}, 32'd8);
        step();
        chk("ack_one_cycle", {28'd0, ack}, 32'd0);
        chk("idle_after_ack", {31'd0, busy}, 32'd0);

        // Single request from requester 2
        step();
        req = 4'b0100;
        sb.push_back(2);
        do_job(20, 1'b0, '0, 1);
        req = '0;
        step();
        step();

        // Stale done: mm_done still high from previous job; pointer is now 3
        req = 4'b0001;
        sb.push_back(0);
        do_job(10, 1'b1, '0, 1);
        req = '0;
        step();
        chk("stale_single_ack", {28'd0, ack}, 32'd0);
        step();

        // Mid-job reset
        req = 4'b0010;
        wait_start(n);
        chk("mid_grant", {30'd0, grant_id}, 32'd1);
        mm_done = 1'b0;
        step();
        step();
        reset = 1'b1;
        req   = 4'b0001;
        step();
        exp_jobs = 0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        chk("mid_rst_jobs", {16'd0, jobs_done}, 32'd0);
        chk("mid_rst_start", {31'd0, mm_start}, 32'd0);
        reset = 1'b0;
        sb.push_back(0);
        do_job(5, 1'b0, '0, 1);
        req = '0;
        step();
        step();

        // Drop request 1 during WAIT; requester 3 is next
        req = 4'b1010;
        sb.push_back(1);
        sb.push_back(3);
        do_job(4, 1'b0, 4'b0010, 1);
        do_job(4, 1'b0, '0, 2);
        req = '0;
        chk("drop_jobs", {16'd0, jobs_done}, 32'd3);
        repeat (3) begin
            step();
            chk("final_idle_start", {31'd0, mm_start}, 32'd0);
        end
        chk("final_busy", {31'd0, busy}, 32'd0);

`ifdef MATMUL_SCHED_TIMEOUT_EN
        // Watchdog: done never rises
        req = 4'b0001;
        wait_start(n);
        mm_done = 1'b0;
        req = '0;
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("wd_cycles", n, 32'd16);
        step();
        chk("wd_ack", {28'd0, ack}, 32'd1);
        chk("wd_pulse_end", {31'd0, timeout}, 32'd0);
        chk("wd_jobs", {16'd0, jobs_done}, exp_jobs);
`else
        chk("timeout_tied", {31'd0, timeout}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
